instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Fetch stage sitting directly upstream of the decode stage and driving the read port of MainMemoryModule. Holds the program counter and issues word reads, PC stepping by 4 per instruction. It buffers returned instructions with their PC in a small FIFO and presents them to decode over a valid/ready handshake. Supports branch/jump redirect with flush, and a halt input.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FIFO_DEPTH, 2, entries in the fetch buffer; power of two, minimum 2.

Ports:
clk  input  1  single clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
memAddress  output  32  read address to main memory; always equals the current PC.
memReadEnable  output  1  high in cycles where a fetch is issued.
memData  input  32  instruction word from memory; combinational, valid in the same cycle as memAddress.
instrValid  output  1  FIFO head holds a valid instruction.
instrReady  input  1  decode accepts the head this cycle.
instruction  output  32  instruction word at FIFO head; 0 when empty.
instrPc  output  32  PC of the FIFO head; 0 when empty.
redirectValid  input  1  branch/jump redirect request.
redirectPc  input  32  redirect target.
halt  input  1  stop issuing new fetches; the FIFO still drains.

Behaviour:
- Reset, sampled at posedge while high: pc <= RESET_PC; FIFO count, head and tail <= 0. While reset is high, memReadEnable=0 and instrValid=0. instruction and instrPc read 0 whenever the FIFO is empty.
- deq = instrValid & instrReady.
- instrValid = (count != 0) & !redirectValid. Forced low in a redirect cycle, so no handshake completes then.
- fetch = memReadEnable = !reset & !redirectValid & !halt & ((count < FIFO_DEPTH) | deq).
  - A full FIFO may fetch in the same cycle it dequeues.
- On fetch at posedge:
  - {memData, pc} is written at the tail; tail advances modulo FIFO_DEPTH.
  - pc <= pc + 4, 32-bit wrap: 32'hFFFF_FFFC -> 0.
- Count update: +1 on fetch only, -1 on deq only, unchanged on both or neither. Count never exceeds FIFO_DEPTH and never goes below 0.
- Latency: an instruction fetched in cycle N appears at the head (instrValid=1) in cycle N+1 if the FIFO was empty. Throughput is 1 instruction per cycle while instrReady=1.
- Order: instructions leave in strict PC order, with no duplicates and no drops, under any instrReady pattern.
- Redirect, sampled at posedge:
  - FIFO flushed (count, head, tail <= 0).
  - pc <= {redirectPc[31:2], 2'b00}; misaligned low bits are silently cleared.
  - No fetch in the redirect cycle; fetching resumes the next cycle from the new pc.
  - Priority: reset > redirect > halt > normal fetch.
- Halt: pc holds and no memory reads are issued. instrValid and deq still operate, so the FIFO drains. Deasserting halt resumes fetching from the held pc.
- memAddress is driven from pc at all times, including when memReadEnable=0. The memory write port is not driven by this block.
- Reset mid-operation (FIFO full, outstanding redirect): all state is discarded. In the cycle after reset deasserts, memAddress=RESET_PC and the first fetch issues.

Test Plan:
- Reset, memory words 0/4/8 = 32'h0022_1800, instrReady=1 -> first cycle after reset: memAddress=0, memReadEnable=1. Following cycles: instrValid=1 with instrPc 0,4,8 on consecutive cycles, instruction=32'h0022_1800.
- instrReady=0 from reset -> two fetches (0,4), then memReadEnable=0 with memAddress held at 8; instrValid=1, instrPc=0 stable. Raise instrReady -> instrPc 0,4,8,12 in order, no gaps after the first, no duplicates.
- FIFO full (pcs 0,4 buffered), redirectValid=1 with redirectPc=32'h40 for one cycle -> instrValid=0 in that cycle and the next. memAddress=32'h40 the next cycle. instrPc=32'h40 the cycle after that.
- redirectPc=32'h43 -> first fetched instrPc=32'h40.
- RESET_PC=32'hFFFF_FFF8, instrReady=1 -> instrPc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- halt=1 with 2 entries buffered, instrReady=1 -> both entries drain, then instrValid=0 and memReadEnable=0 with pc held. Release halt -> fetch resumes at the held pc. Separately, reset asserted with a full FIFO -> instrValid=0 next cycle, memAddress=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch stage: holds the PC, issues one word read per cycle to main memory,
//   buffers {instruction, pc} pairs in a small FIFO and hands them to decode
//   over a valid/ready handshake. Supports redirect (flush + new PC) and halt.
//
// Ports
//   clk            single clock, all state on posedge
//   reset          synchronous, active-high
//   memAddress     read address to memory (always the current PC)
//   memReadEnable  a fetch is issued this cycle
//   memData        instruction word for memAddress, same cycle
//   instrValid     FIFO head holds a valid instruction
//   instrReady     decode accepts the head this cycle
//   instruction    head instruction word (0 when empty)
//   instrPc        head PC (0 when empty)
//   redirectValid  branch/jump redirect request
//   redirectPc     redirect target (low two bits ignored)
//   halt           stop issuing fetches; FIFO still drains
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] memAddress,
  output logic        memReadEnable,
  input  logic [31:0] memData,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instruction,
  output logic [31:0] instrPc,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  input  logic        halt
);

  // FIFO_DEPTH is a power of two, so the pointers wrap naturally.
  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   r_pc;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_instr [FIFO_DEPTH];
  logic [31:0]   r_ipc   [FIFO_DEPTH];

  logic w_empty;
  logic w_deq;
  logic w_fetch;

  assign w_empty = (r_count == '0);

  // Valid is masked during a redirect so no handshake completes on a flushed entry.
  assign instrValid = !reset && !w_empty && !redirectValid;
  assign w_deq      = instrValid && instrReady;

  // A full FIFO can still fetch when the head leaves in the same cycle.
  assign w_fetch = !reset && !redirectValid && !halt &&
                   ((r_count < DEPTH_C) || w_deq);

  assign memReadEnable = w_fetch;
  assign memAddress    = r_pc;
  assign instruction   = w_empty ? 32'h0 : r_instr[r_head];
  assign instrPc       = w_empty ? 32'h0 : r_ipc[r_head];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirectValid) begin
      r_pc    <= {redirectPc[31:2], 2'b00};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_fetch) begin
        r_tail <= r_tail + 1'b1;
        r_pc   <= r_pc + 32'd4;
      end
      if (w_deq) r_head <= r_head + 1'b1;
      case ({w_fetch, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through r_count.
  always_ff @(posedge clk) begin
    if (w_fetch) begin
      r_instr[r_tail] <= memData;
      r_ipc[r_tail]   <= r_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        rv;
  logic [31:0] rpc;
  logic        hlt;
  logic        rdy;

  logic [31:0] addrA, dataA, instA, ipcA;
  logic        mreA, validA;
  logic [31:0] addrB, dataB, instB, ipcB;
  logic        mreB, validB;

  int checks   = 0;
  int failures = 0;

  // Memory image: address-dependent so a wrong entry is visible in the data too.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h0022_1800;
  endfunction

  assign dataA = mem_f(addrA);
  assign dataB = mem_f(addrB);

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dutA (
    .clk(clk), .reset(reset), .memAddress(addrA), .memReadEnable(mreA),
    .memData(dataA), .instrValid(validA), .instrReady(rdy),
    .instruction(instA), .instrPc(ipcA), .redirectValid(rv),
    .redirectPc(rpc), .halt(hlt)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dutB (
    .clk(clk), .reset(reset), .memAddress(addrB), .memReadEnable(mreB),
    .memData(dataB), .instrValid(validB), .instrReady(rdy),
    .instruction(instB), .instrPc(ipcB), .redirectValid(rv),
    .redirectPc(rpc), .halt(hlt)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // head mode: 0 = not checked, 1 = empty (pc/instr 0), 2 = pc e_pc, instr mem_f(e_pc)
  typedef struct packed {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        hlt;
    logic        rdy;
    logic        useB;
    logic        chk_addr;
    logic        e_mre;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [1:0]  hmode;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [31:0] p,
                     input logic h, input logic y, input logic b,
                     input logic ca, input logic m, input logic [31:0] a,
                     input logic vl, input logic [1:0] hm, input logic [31:0] pc);
    vec_t t;
    t = '{rst:r, rv:v, rpc:p, hlt:h, rdy:y, useB:b, chk_addr:ca, e_mre:m,
          e_addr:a, e_valid:vl, hmode:hm, e_pc:pc};
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_row(input vec_t v, input int idx);
    logic [31:0] a, ip, in;
    logic        m, vl;
    a  = v.useB ? addrB  : addrA;
    ip = v.useB ? ipcB   : ipcA;
    in = v.useB ? instB  : instA;
    m  = v.useB ? mreB   : mreA;
    vl = v.useB ? validB : validA;
    chk("memReadEnable", idx, {31'b0, m}, {31'b0, v.e_mre});
    chk("instrValid", idx, {31'b0, vl}, {31'b0, v.e_valid});
    if (v.chk_addr) chk("memAddress", idx, a, v.e_addr);
    if (v.hmode == 2'd1) begin
      chk("instrPc_empty", idx, ip, 32'h0);
      chk("instruction_empty", idx, in, 32'h0);
    end else if (v.hmode == 2'd2) begin
      chk("instrPc", idx, ip, v.e_pc);
      chk("instruction", idx, in, mem_f(v.e_pc));
    end
  endtask

  logic [63:0] sb[$];
  logic [31:0] mpc;
  logic [63:0] ent;
  bit          m_valid, m_deq, m_fetch;

  initial begin
    reset = 1'b1; rv = 1'b0; rpc = '0; hlt = 1'b0; rdy = 1'b0;

    // Straight-line fetch, decode always ready
    add(1,0,0,0,1,0,0,0,0,0,0,0);
    add(1,0,0,0,1,0,1,0,0,0,1,0);
    add(0,0,0,0,1,0,1,1,0,0,1,0);
    add(0,0,0,0,1,0,1,1,4,1,2,0);
    add(0,0,0,0,1,0,1,1,8,1,2,4);
    add(0,0,0,0,1,0,1,1,12,1,2,8);
    // Back-pressure: fill, stall, then stream out in order
    add(1,0,0,0,0,0,0,0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,1,0);
    add(0,0,0,0,0,0,1,1,0,0,1,0);
    add(0,0,0,0,0,0,1,1,4,1,2,0);
    add(0,0,0,0,0,0,1,0,8,1,2,0);
    add(0,0,0,0,0,0,1,0,8,1,2,0);
    add(0,0,0,0,1,0,1,1,8,1,2,0);
    add(0,0,0,0,1,0,1,1,12,1,2,4);
    add(0,0,0,0,1,0,1,1,16,1,2,8);
    add(0,0,0,0,1,0,1,1,20,1,2,12);
    // Redirect with a full FIFO, then a misaligned redirect
    add(1,0,0,0,0,0,0,0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,1,0);
    add(0,0,0,0,0,0,1,1,0,0,1,0);
    add(0,0,0,0,0,0,1,1,4,1,2,0);
    add(0,0,0,0,0,0,1,0,8,1,2,0);
    add(0,1,32'h40,0,0,0,1,0,8,0,2,0);
    add(0,0,0,0,1,0,1,1,32'h40,0,1,0);
    add(0,0,0,0,1,0,1,1,32'h44,1,2,32'h40);
    add(0,0,0,0,1,0,1,1,32'h48,1,2,32'h44);
    add(0,1,32'h43,0,1,0,1,0,32'h4C,0,2,32'h48);
    add(0,0,0,0,1,0,1,1,32'h40,0,1,0);
    add(0,0,0,0,1,0,1,1,32'h44,1,2,32'h40);
    // PC wrap on the instance with RESET_PC = FFFF_FFF8
    add(1,0,0,0,1,1,0,0,0,0,0,0);
    add(1,0,0,0,1,1,1,0,32'hFFFF_FFF8,0,1,0);
    add(0,0,0,0,1,1,1,1,32'hFFFF_FFF8,0,1,0);
    add(0,0,0,0,1,1,1,1,32'hFFFF_FFFC,1,2,32'hFFFF_FFF8);
    add(0,0,0,0,1,1,1,1,32'h0,1,2,32'hFFFF_FFFC);
    add(0,0,0,0,1,1,1,1,32'h4,1,2,32'h0);
    add(0,0,0,0,1,1,1,1,32'h8,1,2,32'h4);
    // Halt drains the FIFO, release resumes; then reset over a full FIFO + redirect
    add(1,0,0,0,0,0,0,0,0,0,0,0);
    add(1,0,0,0,0,0,1,0,0,0,1,0);
    add(0,0,0,0,0,0,1,1,0,0,1,0);
    add(0,0,0,0,0,0,1,1,4,1,2,0);
    add(0,0,0,0,0,0,1,0,8,1,2,0);
    add(0,0,0,1,1,0,1,0,8,1,2,0);
    add(0,0,0,1,1,0,1,0,8,1,2,4);
    add(0,0,0,1,1,0,1,0,8,0,1,0);
    add(0,0,0,0,1,0,1,1,8,0,1,0);
    add(0,0,0,0,1,0,1,1,12,1,2,8);
    add(0,0,0,0,0,0,1,1,16,1,2,12);
    add(0,0,0,0,0,0,1,0,20,1,2,12);
    add(1,1,32'h80,0,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,1,1,0,0,1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; rv = vecs[i].rv; rpc = vecs[i].rpc;
      hlt = vecs[i].hlt; rdy = vecs[i].rdy;
      @(negedge clk);
      check_row(vecs[i], i);
      @(posedge clk); #1;
    end

    // Random traffic against a queue-based reference
    reset = 1'b1; rv = 1'b0; hlt = 1'b0; rdy = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    mpc = 32'h0;
    sb.delete();
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 9) < 7);
      hlt = ($urandom_range(0, 9) < 2);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = $urandom;
      @(negedge clk);
      m_valid = (sb.size() != 0) && !rv;
      m_deq   = m_valid && rdy;
      m_fetch = !rv && !hlt && ((sb.size() < 2) || m_deq);
      chk("rnd_instrValid", 1000 + c, {31'b0, validA}, {31'b0, m_valid});
      chk("rnd_memReadEnable", 1000 + c, {31'b0, mreA}, {31'b0, m_fetch});
      chk("rnd_memAddress", 1000 + c, addrA, mpc);
      if (sb.size() == 0) chk("rnd_empty_pc", 1000 + c, ipcA, 32'h0);
      if (m_deq) begin
        ent = sb.pop_front();
        chk("rnd_instrPc", 1000 + c, ipcA, ent[63:32]);
        chk("rnd_instruction", 1000 + c, instA, ent[31:0]);
      end
      if (rv) begin
        sb.delete();
        mpc = {rpc[31:2], 2'b00};
      end else if (m_fetch) begin
        sb.push_back({mpc, mem_f(mpc)});
        mpc = mpc + 32'd4;
      end
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
